jtcommando_rom_arb: RTL and testbench

- Shares the single jtframe SDRAM read port (sdram_req/sdram_ack/data_rdy/data_read) among four game ROM requesters: main CPU, sound CPU, char/scroll fetch and object fetch.
- Sits between the game logic and jtframe_mist; it drives sdram_addr, sdram_req and refresh_en.
- Each slot gets a latched 32-bit data word and a valid flag.
- Round-robin arbitration keeps the bandwidth fair.

---
 rtl/jtcommando_rom_arb.sv | 169 ++++++++++++++++
 tb/tb_jtcommando_rom_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcommando_rom_arb.sv
// rtl/jtcommando_rom_arb.sv - round-robin arbiter sharing one SDRAM read port among four ROM slots
// Optional one-entry per-slot tag cache enabled by defining ROMARB_CACHE_EN.
module jtcommando_rom_arb #(
    parameter int AW    = 22,
    parameter int DW    = 32,
    parameter int SLOTS = 4
)(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  downloading_i,
    input  logic                  loop_rst_i,
    input  logic [SLOTS-1:0]      slot_cs_i,
    input  logic [SLOTS*AW-1:0]   slot_addr_i,
    output logic [SLOTS-1:0]      slot_ok_o,
    output logic [SLOTS*DW-1:0]   slot_dout_o,
    output logic                  sdram_req_o,
    output logic [AW-1:0]         sdram_addr_o,
    input  logic                  sdram_ack_i,
    input  logic                  data_rdy_i,
    input  logic [DW-1:0]         data_read_i,
    output logic                  refresh_en_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       rr_q, rr_d;
    logic             req_q, req_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    lat_q  [SLOTS];
    logic [AW-1:0]    lat_d  [SLOTS];
    logic [DW-1:0]    dout_q [SLOTS];
    logic [DW-1:0]    dout_d [SLOTS];
    logic [SLOTS-1:0] ok_q, ok_d;
    logic [AW-1:0]    saddr  [SLOTS];
    logic [SLOTS-1:0] match, pend;
    logic             found, capture;
    logic [1:0]       pick, idx;
`ifdef ROMARB_CACHE_EN
    logic [SLOTS-1:0] vld_q, vld_d, hit;
`endif

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            saddr[i] = slot_addr_i[i*AW +: AW];
            match[i] = (saddr[i] == lat_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        req_d   = req_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        dout_d  = dout_q;
        capture = 1'b0;
        found   = 1'b0;
        pick    = rr_q;
        idx     = '0;
`ifdef ROMARB_CACHE_EN
        vld_d   = downloading_i ? '0 : vld_q;
        hit     = slot_cs_i & ~ok_q & vld_q & match & {SLOTS{~downloading_i}};
        pend    = slot_cs_i & ~ok_q & ~hit;
        ok_d    = (ok_q & slot_cs_i & match & {SLOTS{~downloading_i}}) | hit;
`else
        pend    = slot_cs_i & ~ok_q;
        ok_d    = ok_q & slot_cs_i & match & {SLOTS{~downloading_i}};
`endif
        // First pending slot at or after rr_q, wrapping through the 2-bit index
        for (int k = 0; k < SLOTS; k++) begin
            idx = rr_q + 2'(k);
            if (!found && pend[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (!downloading_i && found) begin
                    sel_d       = pick;
                    lat_d[pick] = saddr[pick];
                    addr_d      = saddr[pick];
                    req_d       = 1'b1;
                    state_d     = REQ;
`ifdef ROMARB_CACHE_EN
                    vld_d[pick] = 1'b0;
`endif
                end
            end
            REQ: begin
                if (sdram_ack_i) begin
                    req_d = 1'b0;
                    if (data_rdy_i) begin
                        capture = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (data_rdy_i) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Data for an address the slot no longer wants, or fetched across a download, is dropped
        if (capture) begin
            rr_d = sel_q + 2'd1;
            if (match[sel_q] && slot_cs_i[sel_q] && !downloading_i) begin
                dout_d[sel_q] = data_read_i;
                ok_d[sel_q]   = 1'b1;
`ifdef ROMARB_CACHE_EN
                vld_d[sel_q]  = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || loop_rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ok_q    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                lat_q[i]  <= '0;
                dout_q[i] <= '0;
            end
`ifdef ROMARB_CACHE_EN
            vld_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ok_q    <= ok_d;
            for (int i = 0; i < SLOTS; i++) begin
                lat_q[i]  <= lat_d[i];
                dout_q[i] <= dout_d[i];
            end
`ifdef ROMARB_CACHE_EN
            vld_q   <= vld_d;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            slot_dout_o[i*DW +: DW] = dout_q[i];
        end
    end

    assign slot_ok_o    = ok_q;
    assign sdram_req_o  = req_q;
    assign sdram_addr_o = addr_q;
    assign refresh_en_o = (state_q == IDLE);

endmodule

// File: tb/tb_jtcommando_rom_arb.sv
// tb/tb_jtcommando_rom_arb.sv - directed vector bench for jtcommando_rom_arb
module tb_jtcommando_rom_arb;
    localparam int AW = 22;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1, lrst = 1'b0, dl = 1'b0;
    logic [3:0]    cs = '0;
    logic [AW-1:0] sa [4];
    logic [4*AW-1:0] slot_addr;
    logic [3:0]    ok;
    logic [4*DW-1:0] dout;
    logic          req, ack = 1'b0, rdy = 1'b0, rfsh;
    logic [AW-1:0] saddr;
    logic [DW-1:0] data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign slot_addr = {sa[3], sa[2], sa[1], sa[0]};

    jtcommando_rom_arb #(.AW(AW), .DW(DW), .SLOTS(4)) dut (
        .clk_i(clk), .rst_i(rst), .downloading_i(dl), .loop_rst_i(lrst),
        .slot_cs_i(cs), .slot_addr_i(slot_addr), .slot_ok_o(ok), .slot_dout_o(dout),
        .sdram_req_o(req), .sdram_addr_o(saddr), .sdram_ack_i(ack),
        .data_rdy_i(rdy), .data_read_i(data), .refresh_en_o(rfsh)
    );

    typedef struct packed {
        logic        rst;
        logic        lrst;
        logic        dl;
        logic [3:0]  cs;
        logic        ack;
        logic        rdy;
        logic [31:0] data;
        logic        e_req;
        logic [21:0] e_addr;
        logic        e_rfsh;
        logic [3:0]  e_ok;
        logic [1:0]  dslot;
        logic [31:0] e_dout;
    } vec_t;

    vec_t tbl [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic row(input logic r, input logic l, input logic [3:0] c, input logic a,
                       input logic d, input logic [31:0] dat, input logic er,
                       input logic [21:0] ea, input logic ef, input logic [3:0] eo,
                       input logic [1:0] ds, input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.lrst = l; v.dl = 1'b0; v.cs = c; v.ack = a; v.rdy = d; v.data = dat;
        v.e_req = er; v.e_addr = ea; v.e_rfsh = ef; v.e_ok = eo; v.dslot = ds; v.e_dout = ed;
        tbl.push_back(v);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!req && n < 100) begin
            tick();
            n++;
        end
        if (!req) chk("wait_req timeout", {63'd0, req}, 64'd1);
    endtask

    // Grants the current request: ack after ack_dly cycles, data after rdy_dly more
    task automatic serve(input int ack_dly, input int rdy_dly, input logic [31:0] d,
                         output logic [21:0] ga);
        ga = '0;
        wait_req();
        if (!req) return;
        ga = saddr;
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            chk("req held before ack", {63'd0, req}, 64'd1);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("req drops after ack", {63'd0, req}, 64'd0);
        repeat (rdy_dly) tick();
        rdy = 1'b1;
        data = d;
        tick();
        rdy = 1'b0;
    endtask

    initial begin
        logic [21:0] ga;
        int          exp_slot [5];
        int          s;
        logic        bad;

        sa[0] = 22'h00ABC; sa[1] = 22'h00100; sa[2] = 22'h01234; sa[3] = 22'h02000;

        //  rst lrst cs    ack rdy data           req addr      rf ok    ds dout
        row(1, 0, 4'h0, 0, 0, 32'h0,          0, 22'h00000, 1, 4'h0, 2, 32'h0);
        row(0, 0, 4'h4, 0, 0, 32'h0,          1, 22'h01234, 0, 4'h0, 2, 32'h0);
        row(0, 0, 4'h4, 0, 0, 32'h0,          1, 22'h01234, 0, 4'h0, 2, 32'h0);
        row(0, 0, 4'h4, 0, 0, 32'h0,          1, 22'h01234, 0, 4'h0, 2, 32'h0);
        row(0, 0, 4'h4, 1, 0, 32'h0,          0, 22'h01234, 0, 4'h0, 2, 32'h0);
        row(0, 0, 4'h4, 0, 0, 32'h0,          0, 22'h01234, 0, 4'h0, 2, 32'h0);
        row(0, 0, 4'h4, 0, 0, 32'h0,          0, 22'h01234, 0, 4'h0, 2, 32'h0);
        row(0, 0, 4'h4, 0, 0, 32'h0,          0, 22'h01234, 0, 4'h0, 2, 32'h0);
        row(0, 0, 4'h4, 0, 1, 32'hDEADBEEF,   0, 22'h01234, 1, 4'h4, 2, 32'hDEADBEEF);
        row(0, 0, 4'h4, 0, 0, 32'h0,          0, 22'h01234, 1, 4'h4, 2, 32'hDEADBEEF);
        row(0, 0, 4'h0, 0, 0, 32'h0,          0, 22'h01234, 1, 4'h0, 2, 32'hDEADBEEF);
        row(0, 0, 4'h1, 0, 0, 32'h0,          1, 22'h00ABC, 0, 4'h0, 0, 32'h0);
        row(0, 0, 4'h1, 1, 1, 32'h5A5A5A5A,   0, 22'h00ABC, 1, 4'h1, 0, 32'h5A5A5A5A);
        row(0, 0, 4'h1, 0, 0, 32'h0,          0, 22'h00ABC, 1, 4'h1, 0, 32'h5A5A5A5A);
        row(0, 0, 4'h1, 1, 1, 32'hFFFFFFFF,   0, 22'h00ABC, 1, 4'h1, 0, 32'h5A5A5A5A);
        row(0, 0, 4'h0, 0, 0, 32'h0,          0, 22'h00ABC, 1, 4'h0, 0, 32'h5A5A5A5A);
        row(0, 0, 4'h2, 0, 0, 32'h0,          1, 22'h00100, 0, 4'h0, 0, 32'h5A5A5A5A);
        row(0, 1, 4'h0, 0, 0, 32'h0,          0, 22'h00000, 1, 4'h0, 0, 32'h0);
        row(0, 0, 4'h0, 0, 0, 32'h0,          0, 22'h00000, 1, 4'h0, 0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; lrst = tbl[i].lrst; dl = tbl[i].dl; cs = tbl[i].cs;
            ack = tbl[i].ack; rdy = tbl[i].rdy; data = tbl[i].data;
            tick();
            chk($sformatf("row%0d req", i),     {63'd0, req},  {63'd0, tbl[i].e_req});
            chk($sformatf("row%0d addr", i),    {42'd0, saddr}, {42'd0, tbl[i].e_addr});
            chk($sformatf("row%0d refresh", i), {63'd0, rfsh}, {63'd0, tbl[i].e_rfsh});
            chk($sformatf("row%0d ok", i),      {60'd0, ok},   {60'd0, tbl[i].e_ok});
            chk($sformatf("row%0d dout", i),    {32'd0, dout[tbl[i].dslot*32 +: 32]},
                {32'd0, tbl[i].e_dout});
        end
        rst = 0; lrst = 0; ack = 0; rdy = 0; cs = '0;
        tick();

        // Round robin: all four pending, slot 0 re-requests while 1 is waiting
        exp_slot = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) sa[i] = 22'h300 + 22'(i);
        cs = 4'hF;
        for (int j = 0; j < 5; j++) begin
            serve(1, 2, 32'hA0000000 + 32'(j), ga);
            s = exp_slot[j];
            chk($sformatf("rr%0d addr", j), {42'd0, ga},
                {42'd0, (j == 4) ? 22'h310 : 22'h300 + 22'(s)});
            chk($sformatf("rr%0d ok", j), {63'd0, ok[s]}, 64'd1);
            chk($sformatf("rr%0d dout", j), {32'd0, dout[s*32 +: 32]}, {32'd0, 32'hA0000000 + 32'(j)});
            cs[s] = 1'b0;
            if (j == 0) begin
                tick();
                sa[0] = 22'h310;
                cs[0] = 1'b1;
            end
        end
        cs = '0;
        repeat (2) tick();

        // Address change after ack: data dropped, refetch at new address
        sa[1] = 22'h100;
        cs = 4'h2;
        wait_req();
        chk("achg first addr", {42'd0, saddr}, {42'd0, 22'h100});
        ack = 1; tick(); ack = 0;
        sa[1] = 22'h104;
        repeat (2) tick();
        rdy = 1; data = 32'h11111111; tick(); rdy = 0;
        chk("achg ok stays 0", {63'd0, ok[1]}, 64'd0);
        serve(1, 1, 32'h22222222, ga);
        chk("achg refetch addr", {42'd0, ga}, {42'd0, 22'h104});
        chk("achg ok", {63'd0, ok[1]}, 64'd1);
        chk("achg dout", {32'd0, dout[32 +: 32]}, {32'd0, 32'h22222222});
        cs = '0;
        repeat (2) tick();

        // Download raised during WAIT
        sa[3] = 22'h050;
        cs = 4'h8;
        serve(0, 1, 32'h33330000, ga);
        chk("dl pre ok3", {63'd0, ok[3]}, 64'd1);
        sa[2] = 22'h060;
        cs = 4'hC;
        wait_req();
        chk("dl grant addr", {42'd0, saddr}, {42'd0, 22'h060});
        ack = 1; tick(); ack = 0;
        dl = 1;
        tick();
        chk("dl ok cleared", {60'd0, ok}, 64'd0);
        tick();
        rdy = 1; data = 32'h44444444; tick(); rdy = 0;
        chk("dl idle after data", {63'd0, rfsh}, 64'd1);
        chk("dl data no ok", {60'd0, ok}, 64'd0);
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (req) bad = 1'b1;
        end
        chk("dl no req", {63'd0, bad}, 64'd0);
        dl = 0;
        tick();
        chk("dl resume req", {63'd0, req}, 64'd1);
        chk("dl resume rr addr", {42'd0, saddr}, {42'd0, 22'h050});
        serve(0, 1, 32'h55550000, ga);
        chk("dl slot3 ok", {63'd0, ok[3]}, 64'd1);
        cs[3] = 1'b0;
        serve(0, 1, 32'h66660000, ga);
        chk("dl slot2 addr", {42'd0, ga}, {42'd0, 22'h060});
        chk("dl slot2 ok", {63'd0, ok[2]}, 64'd1);
        cs = '0;
        repeat (2) tick();

        // Re-request of the same address after cs drop
        sa[3] = 22'h2000;
        cs = 4'h8;
        serve(1, 1, 32'hC0DE0000, ga);
        chk("cache first addr", {42'd0, ga}, {42'd0, 22'h2000});
        chk("cache first ok", {63'd0, ok[3]}, 64'd1);
        cs = '0;
        repeat (2) tick();
        chk("cache ok dropped", {63'd0, ok[3]}, 64'd0);
        cs = 4'h8;
        tick();
`ifdef ROMARB_CACHE_EN
        chk("cache hit ok", {63'd0, ok[3]}, 64'd1);
        chk("cache hit no req", {63'd0, req}, 64'd0);
        repeat (2) tick();
        chk("cache hit still no req", {63'd0, req}, 64'd0);
        chk("cache hit dout", {32'd0, dout[96 +: 32]}, {32'd0, 32'hC0DE0000});
`else
        chk("refetch req", {63'd0, req}, 64'd1);
        chk("refetch addr", {42'd0, saddr}, {42'd0, 22'h2000});
        serve(0, 1, 32'hC0DE0001, ga);
        chk("refetch ok", {63'd0, ok[3]}, 64'd1);
        chk("refetch dout", {32'd0, dout[96 +: 32]}, {32'd0, 32'hC0DE0001});
`endif
        cs = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
